// File: rtl/mac_pkg.sv
// Shared constants and result encodings for the floating MAC datapath.
// Holds field layout, exponent limits and the canonical +0 / +INF words.
package mac_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int LZC_W  = 5;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int SIGN_POS = 31;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_W   = 23;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        unf;
  } res_t;

endpackage

// File: rtl/lzc24.sv
// Combinational leading-zero counter for a 24-bit sum, result 0..24.
// Padding the low end with ones bounds the count at 24 for an all-zero input.
module lzc24
  import mac_pkg::*;
(
  input  logic [23:0]      sum_i,
  output logic [LZC_W-1:0] lz_o
);

  logic [31:0]      v;
  logic [LZC_W-1:0] n;

  always_comb begin
    v = {sum_i, 8'hFF};
    n = '0;
    if (v[31:16] == 16'h0) begin n[4] = 1'b1; v = v << 16; end
    if (v[31:24] == 8'h0)  begin n[3] = 1'b1; v = v << 8;  end
    if (v[31:28] == 4'h0)  begin n[2] = 1'b1; v = v << 4;  end
    if (v[31:30] == 2'h0)  begin n[1] = 1'b1; v = v << 2;  end
    if (v[31] == 1'b0)     begin n[0] = 1'b1;              end
    lz_o = n;
  end

endmodule

// File: rtl/mac_normalize_round.sv
// Post-adder normalize / round-to-nearest-even stage of the floating MAC.
// Two-stage valid/ready pipeline; stage 1 aligns and counts zeros, stage 2 shifts, rounds, packs.
module mac_normalize_round #(
  parameter int MANT_W = mac_pkg::MANT_W,
  parameter int EXP_W  = mac_pkg::EXP_W,
  parameter int LZC_W  = mac_pkg::LZC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_sum,
  input  logic              in_cout,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              out_underflow
);
  import mac_pkg::*;

  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] EXP_SAT  = EW2'(EXP_MAX);
  localparam logic signed [EW2-1:0] EXP_ZERO = '0;

  function automatic void rne_round(
    input  logic        [MANT_W-1:0] m,
    input  logic                     g,
    input  logic signed [EW2-1:0]    e,
    output logic        [MANT_W-1:0] m_o,
    output logic signed [EW2-1:0]    e_o
  );
    logic [MANT_W:0] sum;
    // A lone guard bit can only signal an exact half, so round up only when odd.
    sum = {1'b0, m} + {{MANT_W{1'b0}}, g & m[0]};
    if (sum[MANT_W]) begin
      m_o = {1'b1, {(MANT_W-1){1'b0}}};
      e_o = e + EW2'(1);
    end else begin
      m_o = sum[MANT_W-1:0];
      e_o = e;
    end
  endfunction

  function automatic res_t select_result(
    input logic                     sign,
    input logic                     zero,
    input logic                     expmax,
    input logic signed [EW2-1:0]    e,
    input logic        [MANT_W-1:0] m
  );
    res_t r;
    r = '0;
    if (zero) begin
      r.result = POS_ZERO;
      r.zero   = 1'b1;
    end else if (expmax || e >= EXP_SAT) begin
      r.result = POS_INF | {sign, 31'h0};
      r.ovf    = 1'b1;
    end else if (e <= EXP_ZERO) begin
      r.result = {sign, 31'h0};
      r.zero   = 1'b1;
      r.unf    = 1'b1;
    end else begin
      r.result = {sign, e[EXP_W-1:0], m[MANT_W-2:0]};
    end
    return r;
  endfunction

  logic s1_load, s2_load;

  logic                     vld_p1_q;
  logic                     sign_p1_q, sign_p1_d;
  logic        [MANT_W-1:0] mant_p1_q, mant_p1_d;
  logic                     guard_p1_q, guard_p1_d;
  logic signed [EW2-1:0]    exp_p1_q, exp_p1_d;
  logic        [LZC_W-1:0]  lz_p1_q, lz_p1_d;
  logic                     zero_p1_q, zero_p1_d;
  logic                     expmax_p1_q, expmax_p1_d;

  logic                     vld_p2_q;
  res_t                     res_p2_q, res_p2_d;

  logic        [LZC_W-1:0]  lz_raw;
  logic        [MANT_W-1:0] mant_sh, mant_rnd;
  logic signed [EW2-1:0]    exp_sh, exp_rnd;

  assign s2_load  = !vld_p2_q || out_ready;
  assign s1_load  = !vld_p1_q || s2_load;
  assign in_ready = s1_load;

  lzc24 u_lzc (
    .sum_i (in_sum),
    .lz_o  (lz_raw)
  );

  // ---- stage 0 -> 1: carry-out alignment and leading-zero count
  always_comb begin
    sign_p1_d   = in_sign;
    mant_p1_d   = in_sum;
    guard_p1_d  = 1'b0;
    lz_p1_d     = lz_raw;
    exp_p1_d    = $signed({2'b00, in_exp});
    zero_p1_d   = !in_cout && (in_sum == '0);
    expmax_p1_d = (in_exp == EXP_MAX);
    if (in_cout) begin
      mant_p1_d  = {1'b1, in_sum[MANT_W-1:1]};
      guard_p1_d = in_sum[0];
      lz_p1_d    = '0;
      exp_p1_d   = $signed({2'b00, in_exp}) + EW2'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (s1_load && in_valid) begin
      sign_p1_q   <= sign_p1_d;
      mant_p1_q   <= mant_p1_d;
      guard_p1_q  <= guard_p1_d;
      lz_p1_q     <= lz_p1_d;
      exp_p1_q    <= exp_p1_d;
      zero_p1_q   <= zero_p1_d;
      expmax_p1_q <= expmax_p1_d;
    end
  end

  // ---- stage 1 -> 2: normalize shift, round, saturate and pack
  always_comb begin
    mant_sh = mant_p1_q << lz_p1_q;
    exp_sh  = exp_p1_q - $signed({{(EW2-LZC_W){1'b0}}, lz_p1_q});
    rne_round(mant_sh, guard_p1_q, exp_sh, mant_rnd, exp_rnd);
    res_p2_d = select_result(sign_p1_q, zero_p1_q, expmax_p1_q, exp_rnd, mant_rnd);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
    end else begin
      if (s1_load) vld_p1_q <= in_valid;
      if (s2_load) vld_p2_q <= vld_p1_q;
      if (s2_load && vld_p1_q) res_p2_q <= res_p2_d;
    end
  end

  assign out_valid     = vld_p2_q;
  assign out_result    = res_p2_q.result;
  assign out_zero      = res_p2_q.zero;
  assign out_overflow  = res_p2_q.ovf;
  assign out_underflow = res_p2_q.unf;

endmodule

// File: tb/tb_mac_normalize_round.sv
// Bench for mac_normalize_round: value-level float model, scoreboard queue, random traffic.
module tb_mac_normalize_round;
  import mac_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_sum;
  logic        in_cout;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] expq[$];

  mac_normalize_round dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_cout       (in_cout),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Treats {cout,sum} as an unsigned integer whose bit 23 is worth 2^(in_exp-BIAS).
  function automatic logic [34:0] model(input logic [23:0] s, input logic c,
                                        input logic sg, input logic [7:0] ex);
    logic [24:0] v;
    logic [24:0] m;
    int p;
    int e;
    v = {c, s};
    p = -1;
    if (v == 25'h0) return {32'h0, 3'b100};
    for (int i = 0; i < 25; i++) if (v[i]) p = i;
    e = (int'(ex) - BIAS) + (p - 23) + BIAS;
    if (p == 24) begin
      m = v >> 1;
      if (v[0] && m[0]) m = m + 25'd1;
    end else begin
      m = v << (23 - p);
    end
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (ex == 8'hFF || e >= 255) return {sg, 8'hFF, 23'h0, 3'b010};
    if (e <= 0) return {sg, 31'h0, 3'b101};
    return {sg, e[7:0], m[22:0], 3'b000};
  endfunction

  // Scoreboard: outputs and inputs are sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      expq.delete();
    end else begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", {29'h0, out_result, out_zero, out_overflow, out_underflow}, 64'h0);
        end else begin
          chk("stream_result", {29'h0, out_result, out_zero, out_overflow, out_underflow},
              {29'h0, expq[0]});
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (in_valid && in_ready) expq.push_back(model(in_sum, in_cout, in_sign, in_exp));
    end
  end

  task automatic directed(input string name, input logic [23:0] s, input logic c,
                          input logic sg, input logic [7:0] e, input logic [34:0] req);
    @(posedge clock); #1;
    in_valid = 1'b1; in_sum = s; in_cout = c; in_sign = sg; in_exp = e; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk({name, "_early"}, {63'h0, out_valid}, 64'h0);
    @(posedge clock);
    @(negedge clock);
    chk({name, "_valid"}, {63'h0, out_valid}, 64'h1);
    chk(name, {29'h0, out_result, out_zero, out_overflow, out_underflow}, {29'h0, req});
  endtask

  logic [23:0] bp_sum [4];
  logic [7:0]  bp_exp [4];
  int idx;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; in_sign = 1'b0;
    in_exp = '0; out_ready = 1'b1;

    chk("model_one",   {29'h0, model(24'h800000, 1'b0, 1'b0, 8'd127)}, {29'h0, 32'h3F800000, 3'b000});
    chk("model_rne_up", {29'h0, model(24'hFFFFFF, 1'b1, 1'b0, 8'd127)}, {29'h0, 32'h40800000, 3'b000});
    chk("model_lz23",  {29'h0, model(24'h000001, 1'b0, 1'b0, 8'd127)}, {29'h0, 32'h34000000, 3'b000});
    chk("model_inf",   {29'h0, model(24'h800000, 1'b1, 1'b1, 8'd254)}, {29'h0, 32'hFF800000, 3'b010});

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready",  {63'h0, in_ready}, 64'h1);
    chk("rst_outputs",   {28'h0, out_result, out_zero, out_overflow, out_underflow, 1'b0}, 64'h0);

    directed("one",        24'h800000, 1'b0, 1'b0, 8'd127, {32'h3F800000, 3'b000});
    directed("two",        24'h000000, 1'b1, 1'b0, 8'd127, {32'h40000000, 3'b000});
    directed("rne_carry",  24'hFFFFFF, 1'b1, 1'b0, 8'd127, {32'h40800000, 3'b000});
    directed("lz23",       24'h000001, 1'b0, 1'b0, 8'd127, {32'h34000000, 3'b000});
    directed("underflow",  24'h000001, 1'b0, 1'b1, 8'd10,  {32'h80000000, 3'b101});
    directed("zero_neg",   24'h000000, 1'b0, 1'b1, 8'd127, {32'h00000000, 3'b100});
    directed("ovf_pos",    24'h800000, 1'b1, 1'b0, 8'd254, {32'h7F800000, 3'b010});
    directed("ovf_neg",    24'h800000, 1'b1, 1'b1, 8'd254, {32'hFF800000, 3'b010});
    directed("tie_even",   24'h000001, 1'b1, 1'b0, 8'd127, {32'h40000000, 3'b000});
    directed("tie_odd",    24'h000003, 1'b1, 1'b0, 8'd127, {32'h40000002, 3'b000});
    directed("exp_ff",     24'h800000, 1'b0, 1'b0, 8'hFF,  {32'h7F800000, 3'b010});
    directed("min_normal", 24'h800000, 1'b0, 1'b0, 8'd1,   {32'h00800000, 3'b000});
    directed("exp_zero",   24'h800000, 1'b0, 1'b0, 8'd0,   {32'h00000000, 3'b101});

    bp_sum[0] = 24'h800000; bp_exp[0] = 8'd127;
    bp_sum[1] = 24'hC00000; bp_exp[1] = 8'd100;
    bp_sum[2] = 24'h000100; bp_exp[2] = 8'd140;
    bp_sum[3] = 24'h123456; bp_exp[3] = 8'd60;
    idx = 0;
    for (int c = 0; c < 30 && !(idx == 4 && expq.size() == 0); c++) begin
      @(posedge clock); #1;
      out_ready = (c >= 3);
      in_valid  = (idx < 4);
      in_sum    = bp_sum[idx % 4];
      in_exp    = bp_exp[idx % 4];
      in_cout   = 1'b0;
      in_sign   = idx[0];
      @(negedge clock);
      if (c == 2) begin
        chk("bp_in_ready_low", {63'h0, in_ready}, 64'h0);
        chk("bp_accepted_two", 64'(idx), 64'd2);
      end
      if (in_valid && in_ready) idx++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd4);
    chk("bp_drained", 64'(expq.size()), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_cout   = ($urandom_range(0, 9) < 3);
      in_sign   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       in_sum = 24'($urandom);
        1:       in_sum = 24'($urandom) >> $urandom_range(0, 24);
        2:       in_sum = 24'hFFFFFF;
        default: in_sum = ($urandom_range(0, 1) == 0) ? 24'h000000 : 24'h800000;
      endcase
      case ($urandom_range(0, 2))
        0:       in_exp = 8'($urandom_range(0, 255));
        1:       in_exp = 8'($urandom_range(250, 255));
        default: in_exp = 8'($urandom_range(0, 30));
      endcase
      if (i == 1500) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_mid_out_valid", {63'h0, out_valid}, 64'h0);
        chk("reset_mid_in_ready",  {63'h0, in_ready}, 64'h1);
      end
    end

    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && expq.size() != 0; c++) @(negedge clock);
    chk("final_drain", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
